selection_entry: RTL

- Downstream consumer of the keypad scanner's `kp_out` key code.
- Debounces the code and produces exactly one event per physical press.
- Assembles a 1–2 digit product selection with clear (`*`) and enter (`#`) keys.
- Hands the binary selection to the vending controller over a valid/ready handshake, and drives digit-display outputs while entry is in progress.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/key_debounce.sv | 78 +++++++
 rtl/selection_entry.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending selection-entry path.
//   - Keypad scanner codes (ASCII-style) for digits, '*', '#' and "no key".
//   - Entry FSM state encoding.
//   - Display blank code and small decode / conversion helpers.
// ----------------------------------------------------------------------------
package vend_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_STAR = 8'h2A;
    localparam logic [7:0] KEY_HASH = 8'h23;
    localparam logic [7:0] KEY_DIG0 = 8'h30;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOne  = 2'd1,
        StTwo  = 2'd2,
        StPend = 2'd3
    } entry_state_e;

    function automatic logic is_digit(input logic [7:0] code);
        return (code >= KEY_DIG0) && (code <= (KEY_DIG0 + 8'd9));
    endfunction

    // Codes the entry logic understands; everything else reads as "no key".
    function automatic logic is_known_key(input logic [7:0] code);
        return is_digit(code) || (code == KEY_STAR) || (code == KEY_HASH);
    endfunction

    // Two BCD digits (each 0..9) to binary 0..99.
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] hi, input logic [3:0] lo);
        return (7'(hi) * 7'd10) + 7'(lo);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Turns the raw keypad scanner code into one event per physical press.
// A code must be sampled identically for DEBOUNCE consecutive cycles to be
// accepted; a press is only re-armed after "no key" has been stable for the
// same number of cycles, so sliding from one key to another gives no event.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   kp_code  in   [7:0] scanner code
//   key_evt  out  one-cycle pulse, cycle after the DEBOUNCE-th matching sample
//   key_val  out  [7:0] accepted key code, unknown codes mapped to KEY_NONE
// ----------------------------------------------------------------------------
module key_debounce
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kp_code,
    output logic       key_evt,
    output logic [7:0] key_val
);

    localparam int unsigned CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    // r_cnt holds (matching samples - 1), so it saturates at DEBOUNCE-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE - 2);

    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pressed;
    logic             r_evt;
    logic [7:0]       r_val;

    logic [7:0]       w_code;
    logic             w_same;
    logic             w_stable_now;

    assign w_code       = is_known_key(kp_code) ? kp_code : KEY_NONE;
    assign w_same       = (w_code == r_cand);
    // This sample is the DEBOUNCE-th identical one in a row.
    assign w_stable_now = w_same && (r_cnt == CNT_PRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand    <= KEY_NONE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
            r_evt     <= 1'b0;
            r_val     <= KEY_NONE;
        end else begin
            r_evt <= 1'b0;
            if (!w_same) begin
                r_cand <= w_code;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_stable_now) begin
                if (!r_pressed && (w_code != KEY_NONE)) begin
                    r_evt     <= 1'b1;
                    r_val     <= w_code;
                    r_pressed <= 1'b1;
                end else if (r_pressed && (w_code == KEY_NONE)) begin
                    r_pressed <= 1'b0;
                end
            end
        end
    end

    assign key_evt = r_evt;
    assign key_val = r_val;

endmodule

// File: rtl/selection_entry.sv
// ----------------------------------------------------------------------------
// selection_entry
// Assembles a 1-2 digit product selection from debounced keypad events and
// hands it to the vending controller over a valid/ready handshake.
//   digits fill disp_hi then disp_lo, '*' clears, '#' submits.
//   A partial entry idle for TIMEOUT cycles is discarded.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   kp_code    in   [7:0] keypad scanner code
//   sel_ready  in   controller accepts the selection
//   sel_valid  out  selection available, held until accepted
//   sel_code   out  [6:0] binary selection 0..99, stable while sel_valid
//   digit_cnt  out  [1:0] digits entered (0..2)
//   disp_hi    out  [3:0] first digit (BCD), 4'hF when blank
//   disp_lo    out  [3:0] second digit (BCD), 4'hF when blank
//   entry_err  out  one-cycle pulse on an illegal key
// ----------------------------------------------------------------------------
module selection_entry
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned TIMEOUT  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kp_code,
    input  logic       sel_ready,
    output logic       sel_valid,
    output logic [6:0] sel_code,
    output logic [1:0] digit_cnt,
    output logic [3:0] disp_hi,
    output logic [3:0] disp_lo,
    output logic       entry_err
);

    localparam int unsigned IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic             w_key_evt;
    logic [7:0]       w_key_val;
    logic             w_is_digit;
    logic [3:0]       w_digit;

    entry_state_e     r_state,     w_state_nxt;
    logic [6:0]       r_sel_code,  w_sel_code_nxt;
    logic [1:0]       r_digit_cnt, w_digit_cnt_nxt;
    logic [3:0]       r_disp_hi,   w_disp_hi_nxt;
    logic [3:0]       r_disp_lo,   w_disp_lo_nxt;
    logic             r_entry_err, w_entry_err_nxt;
    logic             r_sel_valid, w_sel_valid_nxt;
    logic [IDLE_W-1:0] r_idle,     w_idle_nxt;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debounce (
        .clk     (clk),
        .reset   (reset),
        .kp_code (kp_code),
        .key_evt (w_key_evt),
        .key_val (w_key_val)
    );

    assign w_is_digit = is_digit(w_key_val);
    assign w_digit    = w_key_val[3:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_code_nxt  = r_sel_code;
        w_digit_cnt_nxt = r_digit_cnt;
        w_disp_hi_nxt   = r_disp_hi;
        w_disp_lo_nxt   = r_disp_lo;
        w_entry_err_nxt = 1'b0;
        w_idle_nxt      = r_idle;

        unique case (r_state)
            StIdle: begin
                w_idle_nxt = '0;
                if (w_key_evt) begin
                    if (w_is_digit) begin
                        w_disp_hi_nxt   = w_digit;
                        w_digit_cnt_nxt = 2'd1;
                        w_state_nxt     = StOne;
                    end else if (w_key_val == KEY_HASH) begin
                        w_entry_err_nxt = 1'b1;
                    end
                end
            end

            StOne, StTwo: begin
                if (w_key_evt) begin
                    // Any key restarts the idle window, and beats a coincident timeout.
                    w_idle_nxt = '0;
                    if (w_is_digit) begin
                        if (r_state == StOne) begin
                            w_disp_lo_nxt   = w_digit;
                            w_digit_cnt_nxt = 2'd2;
                            w_state_nxt     = StTwo;
                        end else begin
                            w_entry_err_nxt = 1'b1;
                        end
                    end else if (w_key_val == KEY_HASH) begin
                        w_sel_code_nxt = (r_state == StOne) ? 7'(r_disp_hi)
                                                            : bcd2_to_bin(r_disp_hi, r_disp_lo);
                        w_state_nxt    = StPend;
                    end else begin
                        w_disp_hi_nxt   = BCD_BLANK;
                        w_disp_lo_nxt   = BCD_BLANK;
                        w_digit_cnt_nxt = 2'd0;
                        w_state_nxt     = StIdle;
                    end
                end else if (r_idle == IDLE_LAST) begin
                    w_idle_nxt      = '0;
                    w_disp_hi_nxt   = BCD_BLANK;
                    w_disp_lo_nxt   = BCD_BLANK;
                    w_digit_cnt_nxt = 2'd0;
                    w_state_nxt     = StIdle;
                end else begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                end
            end

            StPend: begin
                // Keys are dropped here; displays hold until the controller accepts.
                w_idle_nxt = '0;
                if (sel_ready) begin
                    w_disp_hi_nxt   = BCD_BLANK;
                    w_disp_lo_nxt   = BCD_BLANK;
                    w_digit_cnt_nxt = 2'd0;
                    w_state_nxt     = StIdle;
                end
            end
        endcase

        w_sel_valid_nxt = (w_state_nxt == StPend);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_sel_code  <= '0;
            r_digit_cnt <= 2'd0;
            r_disp_hi   <= BCD_BLANK;
            r_disp_lo   <= BCD_BLANK;
            r_entry_err <= 1'b0;
            r_sel_valid <= 1'b0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_code  <= w_sel_code_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_disp_hi   <= w_disp_hi_nxt;
            r_disp_lo   <= w_disp_lo_nxt;
            r_entry_err <= w_entry_err_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    assign sel_valid = r_sel_valid;
    assign sel_code  = r_sel_code;
    assign digit_cnt = r_digit_cnt;
    assign disp_hi   = r_disp_hi;
    assign disp_lo   = r_disp_lo;
    assign entry_err = r_entry_err;

endmodule
